// File: rtl/router_out_reader.sv
// Drains one packet at a time from a router output FIFO: header, payload, parity byte.
// Streams the payload on dout/dout_vld and aborts cleanly when the port is soft-reset.
module router_out_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic              soft_reset,
    input  logic [DATA_W-1:0] data_out,
    input  logic [4:0]        rd_delay,
    output logic              read_enb,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              pkt_abort,
    output logic              busy
);

    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        HDR_RD  = 3'd2,
        HDR_CAP = 3'd3,
        BODY    = 3'd4,
        CHECK   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   issue_rem_q, issue_rem_d;
    logic [CNT_W-1:0]   cap_rem_q, cap_rem_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic               par_ok_q, par_ok_d;
    logic               rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_vld_q, dout_vld_d;
    logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
    logic               pkt_abort_q, pkt_abort_d;
    logic [CNT_W-1:0]   hdr_cnt;

    // Header + payload + parity: len+1 more bytes to fetch after the header.
    assign hdr_cnt  = CNT_W'(data_out[DATA_W-1:2]) + CNT_W'(1);

    assign read_enb = vld_out &&
                      ((state_q == HDR_RD) ||
                       ((state_q == BODY) && (issue_rem_q != '0)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            issue_rem_q <= '0;
            cap_rem_q   <= '0;
            par_q       <= '0;
            par_ok_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            pkt_len_q   <= '0;
            pkt_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            issue_rem_q <= issue_rem_d;
            cap_rem_q   <= cap_rem_d;
            par_q       <= par_d;
            par_ok_q    <= par_ok_d;
            rd_pend_q   <= rd_pend_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            pkt_len_q   <= pkt_len_d;
            pkt_abort_q <= pkt_abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        issue_rem_d = issue_rem_q;
        cap_rem_d   = cap_rem_q;
        par_d       = par_q;
        par_ok_d    = par_ok_q;
        rd_pend_d   = read_enb;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_abort_d = 1'b0;

        if (soft_reset && (state_q != IDLE)) begin
            // FIFO is being flushed: drop any byte still in flight.
            state_d     = IDLE;
            issue_rem_d = '0;
            cap_rem_d   = '0;
            par_d       = '0;
            rd_pend_d   = 1'b0;
            pkt_abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_out && !soft_reset) begin
                        dcnt_d  = rd_delay;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (dcnt_q == '0) state_d = HDR_RD;
                    else              dcnt_d  = dcnt_q - 5'd1;
                end
                HDR_RD: begin
                    if (vld_out) state_d = HDR_CAP;
                end
                HDR_CAP: begin
                    pkt_len_d   = data_out[DATA_W-1:2];
                    par_d       = data_out;
                    issue_rem_d = hdr_cnt;
                    cap_rem_d   = hdr_cnt;
                    state_d     = BODY;
                end
                BODY: begin
                    if (read_enb) issue_rem_d = issue_rem_q - CNT_W'(1);
                    if (rd_pend_q) begin
                        cap_rem_d = cap_rem_q - CNT_W'(1);
                        if (cap_rem_q > CNT_W'(1)) begin
                            dout_d     = data_out;
                            dout_vld_d = 1'b1;
                            par_d      = par_q ^ data_out;
                        end else begin
                            // Last byte of the packet is the parity byte.
                            par_ok_d = (par_q == data_out);
                            state_d  = CHECK;
                        end
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_abort  = pkt_abort_q;
    assign busy       = (state_q != IDLE);
    assign pkt_done   = (state_q == CHECK) && !soft_reset;
    assign parity_err = pkt_done && !par_ok_q;

endmodule

// File: tb/tb_router_out_reader.sv
// Bench for router_out_reader: queue-backed FIFO model, directed + randomized packets.
module tb_router_out_reader;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              soft_reset = 1'b0;
    logic [4:0]        rd_delay = 5'd0;
    logic [DATA_W-1:0] data_out = '0;
    logic              vld_out;
    logic              read_enb;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic [LEN_W-1:0]  pkt_len;
    logic              pkt_done, parity_err, pkt_abort, busy;

    router_out_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .soft_reset(soft_reset),
        .data_out(data_out), .rd_delay(rd_delay), .read_enb(read_enb),
        .dout(dout), .dout_vld(dout_vld), .pkt_len(pkt_len), .pkt_done(pkt_done),
        .parity_err(parity_err), .pkt_abort(pkt_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a handshake; soft_reset flushes.
    logic [7:0] mem [0:4095];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    bit  hold   = 1'b0;
    assign vld_out = (wr_ptr != rd_ptr) && !hold;

    always @(posedge clk) begin
        if (soft_reset) rd_ptr <= wr_ptr;
        else if (read_enb && vld_out) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    logic [7:0] obs[$];
    int  rd_cyc[$], done_cyc[$], done_len[$];
    int  n_rd = 0, n_done = 0, n_perr = 0, n_perr_done = 0, n_abort = 0, n_bad_re = 0;
    int  last_rise = 0;
    bit  vld_prev = 1'b0;
    always @(negedge clk) begin
        if (dout_vld) obs.push_back(dout);
        if (read_enb && vld_out) begin n_rd++; rd_cyc.push_back(cyc); end
        if (read_enb && !vld_out) n_bad_re++;
        if (pkt_done) begin n_done++; done_cyc.push_back(cyc); done_len.push_back(int'(pkt_len)); end
        if (parity_err) begin n_perr++; if (pkt_done) n_perr_done++; end
        if (pkt_abort) n_abort++;
        if (vld_out && !vld_prev) last_rise = cyc;
        vld_prev = vld_out;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] pl [0:63];
    logic [7:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Reference packet builder: header {len,addr}, payload, XOR parity.
    task automatic push_pkt(input int len, input int addr, input logic [7:0] flip);
        logic [7:0] h, p;
        h = {len[5:0], addr[1:0]};
        p = h;
        push_byte(h);
        for (int i = 0; i < len; i++) begin
            push_byte(pl[i]);
            expq.push_back(pl[i]);
            p = p ^ pl[i];
        end
        push_byte(p ^ flip);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    task automatic wait_done(input int target);
        int b;
        b = 0;
        while (n_done < target && b < 2000) begin step(); b++; end
        chk("done_count", 64'(n_done), 64'(target));
    endtask

    task automatic cmp_payload(input string tag, input int base);
        chk({tag, "_beats"}, 64'(obs.size() - base), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk({tag, "_byte"}, 64'((base + i < obs.size()) ? obs[base + i] : 8'hxx), 64'(expq[i]));
    endtask

    initial begin
        int ob, rb, db, pe, b, rd, ln, ab;

        // Reset
        resetn = 1'b0;
        repeat (3) step();
        chk("rst_outs", 64'({read_enb, dout_vld, pkt_done, parity_err, pkt_abort, busy}), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_len", 64'(pkt_len), 64'(0));
        resetn = 1'b1;
        step();

        // 1: len=4 addr=2 fixed payload, rd_delay=0
        rd_delay = 5'd0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        expq.delete(); ob = obs.size(); rb = rd_cyc.size(); db = done_cyc.size(); pe = n_perr;
        push_pkt(4, 2, 8'h00);
        wait_done(db + 1);
        chk("t1_reads", 64'(rd_cyc.size() - rb), 64'(6));
        chk("t1_body_start", 64'(rd_cyc[rb + 1]), 64'(rd_cyc[rb] + 2));
        chk("t1_body_end", 64'(rd_cyc[rb + 5]), 64'(rd_cyc[rb] + 6));
        chk("t1_done_cyc", 64'(done_cyc[db]), 64'(rd_cyc[rb] + 8));
        chk("t1_hdr_lat", 64'(rd_cyc[rb]), 64'(last_rise + 2));
        cmp_payload("t1", ob);
        chk("t1_perr", 64'(n_perr), 64'(pe));
        chk("t1_len", 64'(pkt_len), 64'(4));

        // 2: empty payload
        expq.delete(); ob = obs.size(); rb = rd_cyc.size(); db = done_cyc.size(); pe = n_perr;
        push_pkt(0, 1, 8'h00);
        wait_done(db + 1);
        chk("t2_reads", 64'(rd_cyc.size() - rb), 64'(2));
        chk("t2_beats", 64'(obs.size() - ob), 64'(0));
        chk("t2_perr", 64'(n_perr), 64'(pe));
        chk("t2_len", 64'(pkt_len), 64'(0));

        // 3: corrupted parity
        fill_rand(3);
        expq.delete(); ob = obs.size(); db = done_cyc.size(); pe = n_perr;
        push_pkt(3, 0, 8'h80);
        wait_done(db + 1);
        cmp_payload("t3", ob);
        chk("t3_perr", 64'(n_perr), 64'(pe + 1));
        chk("t3_perr_with_done", 64'(n_perr_done), 64'(pe + 1));

        // 4: vld_out gap mid-payload
        fill_rand(8);
        expq.delete(); ob = obs.size(); rb = rd_cyc.size(); db = done_cyc.size();
        push_pkt(8, 3, 8'h00);
        b = 0;
        while (obs.size() < ob + 3 && b < 200) begin step(); b++; end
        chk("t4_reach_gap", 64'(obs.size() >= ob + 3), 64'(1));
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_gap_re", 64'(read_enb), 64'(0));
            step();
        end
        hold = 1'b0;
        wait_done(db + 1);
        cmp_payload("t4", ob);
        chk("t4_reads", 64'(rd_cyc.size() - rb), 64'(10));

        // 5: soft_reset during long pre-read delay, then recovery
        rd_delay = 5'd31;
        fill_rand(5);
        expq.delete(); rb = rd_cyc.size(); db = n_done; ab = n_abort;
        push_pkt(5, 1, 8'h00);
        repeat (10) step();
        chk("t5_busy_delay", 64'(busy), 64'(1));
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("t5_abort", 64'(pkt_abort), 64'(1));
        chk("t5_idle", 64'(busy), 64'(0));
        step();
        chk("t5_abort_pulse", 64'(pkt_abort), 64'(0));
        repeat (5) step();
        chk("t5_no_reads", 64'(rd_cyc.size() - rb), 64'(0));
        chk("t5_no_done", 64'(n_done), 64'(db));
        chk("t5_abort_cnt", 64'(n_abort), 64'(ab + 1));
        rd_delay = 5'd0;
        fill_rand(4);
        expq.delete(); ob = obs.size(); db = done_cyc.size();
        push_pkt(4, 2, 8'h00);
        wait_done(db + 1);
        cmp_payload("t5r", ob);
        chk("t5r_len", 64'(pkt_len), 64'(4));

        // 6: two back-to-back len=2 packets
        expq.delete(); ob = obs.size(); rb = rd_cyc.size(); db = done_cyc.size(); pe = n_perr;
        fill_rand(2); push_pkt(2, 0, 8'h00);
        fill_rand(2); push_pkt(2, 3, 8'h00);
        wait_done(db + 2);
        cmp_payload("t6", ob);
        chk("t6_hdr2_gap", 64'(rd_cyc[rb + 4]), 64'(done_cyc[db] + 3));
        chk("t6_len1", 64'(done_len[db]), 64'(2));
        chk("t6_len2", 64'(done_len[db + 1]), 64'(2));
        chk("t6_perr", 64'(n_perr), 64'(pe));

        // 7: randomized delay / length / address
        for (int k = 0; k < 4; k++) begin
            rd = $urandom_range(0, 31);
            ln = $urandom_range(1, 40);
            rd_delay = 5'(rd);
            fill_rand(ln);
            expq.delete(); ob = obs.size(); rb = rd_cyc.size(); db = done_cyc.size(); pe = n_perr;
            push_pkt(ln, int'($urandom_range(0, 3)), 8'h00);
            wait_done(db + 1);
            chk("t7_hdr_lat", 64'(rd_cyc[rb]), 64'(last_rise + rd + 2));
            chk("t7_reads", 64'(rd_cyc.size() - rb), 64'(ln + 2));
            cmp_payload("t7", ob);
            chk("t7_len", 64'(pkt_len), 64'(ln));
            chk("t7_perr", 64'(n_perr), 64'(pe));
        end

        // 8: resetn mid-packet
        rd_delay = 5'd0;
        fill_rand(8);
        expq.delete(); ob = obs.size(); db = n_done;
        push_pkt(8, 1, 8'h00);
        b = 0;
        while (obs.size() < ob + 2 && b < 200) begin step(); b++; end
        resetn = 1'b0;
        soft_reset = 1'b1;
        step();
        chk("t8_busy", 64'(busy), 64'(0));
        chk("t8_len", 64'(pkt_len), 64'(0));
        chk("t8_dout", 64'({dout_vld, dout}), 64'(0));
        resetn = 1'b1;
        soft_reset = 1'b0;
        repeat (3) step();
        chk("t8_stay_idle", 64'(busy), 64'(0));
        chk("t8_no_done", 64'(n_done), 64'(db));

        chk("re_without_vld", 64'(n_bad_re), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_out_reader.md
Name: router_out_reader

Overview:
Consumer-side engine for one router output port. It watches the port's vld_out and drains one packet from the output FIFO through read_enb. It parses the header, streams the payload out, checks the trailing parity byte and reports completion. A programmable pre-read delay lets the bench drive the synchronizer's 30-cycle soft-reset timeout. If soft_reset flushes the FIFO mid-packet, the block aborts cleanly.

Parameters:
DATA_W, 8, FIFO data width; header and parity bytes are DATA_W bits.
LEN_W, 6, payload length field width, held in header bits [DATA_W-1:2].

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
vld_out  input  1  port FIFO non-empty (from the synchronizer)
soft_reset  input  1  port soft reset (from the synchronizer); FIFO is flushed
data_out  input  DATA_W  FIFO read data, valid the cycle after a read_enb/vld_out handshake
rd_delay  input  5  idle cycles to wait after vld_out before the first read
read_enb  output  1  FIFO read request
dout  output  DATA_W  payload byte
dout_vld  output  1  dout valid (payload bytes only)
pkt_len  output  LEN_W  length of the current/last packet
pkt_done  output  1  one-cycle pulse: packet fully consumed
parity_err  output  1  one-cycle pulse with pkt_done when parity mismatches
pkt_abort  output  1  one-cycle pulse: packet aborted by soft_reset
busy  output  1  state != IDLE

Behaviour:
- Packet format: header byte {len[5:0], addr[1:0]}, then len payload bytes (len 0..63), then a parity byte.
  - Parity = XOR of the header and all payload bytes.
- Reset values: all outputs 0. Internal counters 0. State IDLE.
- FIFO read latency is 1. A read is issued in a cycle only when read_enb && vld_out. The byte appears on data_out in the next cycle and is captured on that edge.
- read_enb = vld_out && (state==HDR_RD || (state==BODY && issue_rem!=0)). This is combinational from registered state plus vld_out. read_enb is never high when vld_out is low.
- States:
  - IDLE: when vld_out && !soft_reset, load dcnt=rd_delay and go to DELAY.
  - DELAY: if dcnt==0, go to HDR_RD; otherwise decrement dcnt.
  - HDR_RD:
    - If vld_out, issue one read and go to HDR_CAP.
    - If vld_out is low, stay.
  - HDR_CAP:
    - Capture the header. pkt_len <= data_out[7:2]. par <= data_out.
    - issue_rem <= len+1 and cap_rem <= len+1.
    - Go to BODY.
  - BODY:
    - Issue reads while issue_rem!=0 && vld_out; decrement issue_rem per issued read.
    - Each captured byte decrements cap_rem.
    - If cap_rem>1 on capture, the byte is payload: dout <= byte, dout_vld pulses 1 cycle, par ^= byte.
    - If cap_rem==1 on capture, the byte is parity: go to CHECK with par_ok <= (par==byte).
  - CHECK:
    - Pulse pkt_done.
    - Pulse parity_err if !par_ok.
    - Go to IDLE.
- Back-to-back reads in BODY: one byte per cycle when vld_out stays high. If vld_out drops, reads pause and resume when it returns; there is no internal timeout.
- Latency: header read is issued 1+rd_delay+1 cycles after vld_out rises. pkt_done comes 1 cycle after the parity capture.
- soft_reset in any state other than IDLE:
  - Next state IDLE. issue_rem, cap_rem and par are cleared.
  - pkt_abort pulses 1 cycle. No pkt_done and no dout_vld.
  - An in-flight captured byte in that cycle is discarded.
- soft_reset in IDLE: remain in IDLE and ignore vld_out in that cycle.
- A new packet can start in the cycle after CHECK (IDLE samples vld_out).
- pkt_len holds its value until the next header capture.
- resetn low mid-packet: immediate return to reset values on the next edge.

Test Plan:
1. rd_delay=0; packet len=4, addr=2, payload 11,22,33,44, correct parity:
   - read_enb high 1 cycle for the header, then 5 consecutive cycles.
   - dout_vld pulses 4 times with 11,22,33,44.
   - pkt_done=1 and parity_err=0 one cycle after the parity byte. pkt_len=4.
2. len=0 packet (header 8'h01, parity 8'h01):
   - No dout_vld.
   - pkt_done pulse with parity_err=0.
   - Exactly 2 reads total.
3. len=3 with a corrupted parity byte (expected ^ 8'h80):
   - 3 payload beats.
   - pkt_done and parity_err high in the same cycle.
4. vld_out deasserted for 5 cycles mid-payload of a len=8 packet:
   - read_enb low during the gap.
   - All 8 bytes delivered in order.
   - Total reads = 10; pkt_done once.
5. rd_delay=31 with a packet waiting:
   - Synchronizer soft_reset fires before the header read.
   - pkt_abort pulses; block returns to IDLE; no pkt_done.
   - The next packet with rd_delay=0 completes normally.
6. Two back-to-back len=2 packets in the FIFO, rd_delay=0:
   - Both complete.
   - Second header read issued 3 cycles after the first pkt_done.
   - pkt_len updates 4→2 correctly.
